// File: rtl/gray_code_counter.sv
// rtl/gray_code_counter.sv - up/down counter presenting its value as Gray code behind a valid/ready handshake
// Optional macro: GRAY_CNT_SAT_EN selects saturating mode (no wrap) instead of modulo wrap.
module gray_code_counter #(
  parameter int N = 4
) (
  input  logic         clk,
  input  logic         rstn,
  input  logic         en,
  input  logic         up,
  input  logic         load,
  input  logic [N-1:0] load_value,
  input  logic         out_ready,
  output logic [N-1:0] gray_value,
  output logic         out_valid,
  output logic         wrap,
  output logic [N-1:0] count_bin
);

  typedef enum logic {
    IDLE = 1'b0,
    PEND = 1'b1
  } state_t;

  localparam logic [N-1:0] CNT_MAX = '1;
  localparam logic [N-1:0] CNT_MIN = '0;

  state_t       state;
  state_t       state_nxt;
  logic         stall;
  logic         at_edge;
  logic         step_ok;
  logic         wrap_nxt;
  logic [N-1:0] count_nxt;

  // Step qualification: a step is honoured only when the current code is not stuck behind backpressure
  always_comb begin
    stall    = (state == PEND) & ~out_ready;
    at_edge  = up ? (count_bin == CNT_MAX) : (count_bin == CNT_MIN);
`ifdef GRAY_CNT_SAT_EN
    // At the end of the range the request is dropped entirely, so it never produces a new code
    step_ok  = en & ~stall & ~at_edge;
    wrap_nxt = 1'b0;
`else
    step_ok  = en & ~stall;
    wrap_nxt = ~load & step_ok & at_edge;
`endif
  end

  // Next count: load beats a step, a step beats hold
  always_comb begin
    count_nxt = count_bin;
    if (load) begin
      count_nxt = load_value;
    end else if (step_ok) begin
      count_nxt = up ? (count_bin + N'(1)) : (count_bin - N'(1));
    end
  end

  // Handshake next state: a fresh code (load or honoured step) or an unconsumed one keeps valid high
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: begin
        if (load || step_ok) state_nxt = PEND;
      end
      PEND: begin
        if (out_ready && !load && !step_ok) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Handshake state register
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Binary and Gray registers load from the same next-count so they never skew
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      count_bin  <= '0;
      gray_value <= '0;
      wrap       <= 1'b0;
    end else begin
      count_bin  <= count_nxt;
      gray_value <= count_nxt ^ (count_nxt >> 1);
      wrap       <= wrap_nxt;
    end
  end

  assign out_valid = (state == PEND);

endmodule

// File: tb/tb_gray_code_counter.sv
// tb/tb_gray_code_counter.sv - directed and randomized self-checking bench for gray_code_counter
module tb_gray_code_counter;

  localparam int N = 4;
  localparam int MODV = 1 << N;

  logic         clk;
  logic         rstn;
  logic         en;
  logic         up;
  logic         load;
  logic [N-1:0] load_value;
  logic         out_ready;
  logic [N-1:0] gray_value;
  logic         out_valid;
  logic         wrap;
  logic [N-1:0] count_bin;

  int pass_cnt = 0;
  int total_cnt = 0;

  // Reference model state: plain integers
  int m_count = 0;
  int m_valid = 0;
  int m_wrap  = 0;

  gray_code_counter #(.N(N)) dut (
    .clk        (clk),
    .rstn       (rstn),
    .en         (en),
    .up         (up),
    .load       (load),
    .load_value (load_value),
    .out_ready  (out_ready),
    .gray_value (gray_value),
    .out_valid  (out_valid),
    .wrap       (wrap),
    .count_bin  (count_bin)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic int to_gray(input int b);
    return (b ^ (b / 2)) % MODV;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total_cnt++;
    assert (obs === exp) pass_cnt++;
    else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
  endtask

  task automatic model_reset();
    m_count = 0;
    m_valid = 0;
    m_wrap  = 0;
  endtask

  // Advance the model by one clock edge from the specification's rules
  task automatic model_edge(input logic l, input int lv, input logic e, input logic u, input logic r);
    int stalled;
    stalled = (m_valid != 0) && !r;
    m_wrap = 0;
    if (l) begin
      m_count = lv;
      m_valid = 1;
    end else if (e && !stalled) begin
      int target;
      int crosses;
      target  = u ? m_count + 1 : m_count - 1;
      crosses = (target < 0) || (target >= MODV);
`ifdef GRAY_CNT_SAT_EN
      if (crosses) begin
        m_valid = 0;
      end else begin
        m_count = target;
        m_valid = 1;
      end
`else
      m_count = (target + MODV) % MODV;
      m_valid = 1;
      m_wrap  = crosses;
`endif
    end else begin
      m_valid = stalled;
    end
  endtask

  task automatic cmp_model(input string tag);
    chk({tag, ".count"}, 32'(count_bin), 32'(m_count));
    chk({tag, ".gray"},  32'(gray_value), 32'(to_gray(m_count)));
    chk({tag, ".valid"}, 32'(out_valid), 32'(m_valid));
    chk({tag, ".wrap"},  32'(wrap), 32'(m_wrap));
  endtask

  // Apply one cycle of inputs, clock it, then compare against the model away from the edge
  task automatic cyc(input string tag, input logic l, input logic [N-1:0] lv,
                     input logic e, input logic u, input logic r);
    logic [N-1:0] g_prev;
    g_prev     = gray_value;
    load       = l;
    load_value = lv;
    en         = e;
    up         = u;
    out_ready  = r;
    @(posedge clk);
    model_edge(l, int'(lv), e, u, r);
    #1;
    cmp_model(tag);
    if (!l && (gray_value !== g_prev)) chk({tag, ".onebit"}, 32'($countones(gray_value ^ g_prev)), 32'd1);
  endtask

  task automatic do_reset();
    @(posedge clk);
    #1;
    rstn = 1'b0;
    #2;
    model_reset();
    cmp_model("reset");
    #3;
    rstn = 1'b1;
    load = 1'b0;
    en   = 1'b0;
  endtask

  initial begin
    rstn = 1'b0;
    en = 1'b0;
    up = 1'b0;
    load = 1'b0;
    load_value = '0;
    out_ready = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    cmp_model("por");
    rstn = 1'b1;

    // Up count from reset
    for (int i = 0; i < 5; i++) cyc("upcnt", 1'b0, 4'h0, 1'b1, 1'b1, 1'b1);
    chk("upcnt.final_gray", 32'(gray_value), 32'h7);

    // Down wrap from reset
    do_reset();
    cyc("dnwrap", 1'b0, 4'h0, 1'b1, 1'b0, 1'b1);
`ifdef GRAY_CNT_SAT_EN
    chk("dnwrap.count_const", 32'(count_bin), 32'h0);
    chk("dnwrap.valid_const", 32'(out_valid), 32'h0);
`else
    chk("dnwrap.count_const", 32'(count_bin), 32'hF);
    chk("dnwrap.gray_const", 32'(gray_value), 32'h8);
    chk("dnwrap.wrap_const", 32'(wrap), 32'h1);
`endif
    cyc("dnwrap.after", 1'b0, 4'h0, 1'b0, 1'b0, 1'b1);

    // Load with simultaneous en, then step
    cyc("load", 1'b1, 4'hA, 1'b1, 1'b1, 1'b1);
    chk("load.gray_const", 32'(gray_value), 32'hF);
    cyc("load.step", 1'b0, 4'h0, 1'b1, 1'b1, 1'b1);
    chk("load.step_const", 32'(gray_value), 32'hE);

    // Backpressure holds the code, release continues with the next one
    cyc("bp.load", 1'b1, 4'h3, 1'b0, 1'b1, 1'b1);
    for (int i = 0; i < 4; i++) cyc("bp.stall", 1'b0, 4'h0, 1'b1, 1'b1, 1'b0);
    chk("bp.hold_const", 32'(gray_value), 32'h2);
    cyc("bp.release", 1'b0, 4'h0, 1'b1, 1'b1, 1'b1);
    chk("bp.next_const", 32'(gray_value), 32'h6);

    // Load while stalled overwrites the unconsumed code
    cyc("bp.stall2", 1'b0, 4'h0, 1'b1, 1'b1, 1'b0);
    cyc("bp.ldstall", 1'b1, 4'hC, 1'b1, 1'b0, 1'b0);

    // Up wrap after a load; load to the wrap target never flags wrap
    cyc("upwrap.load", 1'b1, 4'hE, 1'b0, 1'b1, 1'b1);
    cyc("upwrap.s1", 1'b0, 4'h0, 1'b1, 1'b1, 1'b1);
    chk("upwrap.s1_const", 32'(gray_value), 32'h8);
    cyc("upwrap.s2", 1'b0, 4'h0, 1'b1, 1'b1, 1'b1);
`ifndef GRAY_CNT_SAT_EN
    chk("upwrap.s2_wrap_const", 32'(wrap), 32'h1);
`endif
    cyc("upwrap.s3", 1'b0, 4'h0, 1'b0, 1'b1, 1'b1);
    cyc("ldzero", 1'b1, 4'h0, 1'b0, 1'b1, 1'b1);
    cyc("idle", 1'b0, 4'h0, 1'b0, 1'b1, 1'b1);

    // Asynchronous reset mid-operation
    cyc("mid.load", 1'b1, 4'h5, 1'b0, 1'b1, 1'b0);
    #2;
    rstn = 1'b0;
    #1;
    chk("mid.count_async", 32'(count_bin), 32'h0);
    chk("mid.gray_async", 32'(gray_value), 32'h0);
    chk("mid.valid_async", 32'(out_valid), 32'h0);
    model_reset();
    #2;
    rstn = 1'b1;
    cyc("mid.first", 1'b0, 4'h0, 1'b1, 1'b1, 1'b1);
    chk("mid.first_const", 32'(gray_value), 32'h1);

    // Randomized traffic against the model
    for (int i = 0; i < 600; i++) begin
      logic       rl;
      logic [N-1:0] rv;
      rl = ($urandom_range(0, 9) == 0);
      rv = N'($urandom);
      cyc("rand", rl, rv, 1'($urandom), 1'($urandom_range(0, 4) != 0), 1'($urandom_range(0, 3) != 0));
    end

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
